antirebote_multicanal: RTL



---
 rtl/antirebote_pkg.sv | 12 +
 rtl/antirebote_canal.sv | 78 +++++++
 rtl/antirebote_multicanal.sv | 63 ++++++
 3 files changed

// File: rtl/antirebote_pkg.sv
// Shared constants and helpers for the multichannel debouncer.
package antirebote_pkg;

    localparam int DEF_STABLE_TICKS = 4;
    localparam int DEF_PRESCALE     = 1;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/antirebote_canal.sv
// One debounce channel: 2-FF synchroniser, stability counter, clean level
// and registered one-cycle rise/fall pulses.
module antirebote_canal
    import antirebote_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic en,
    input  logic x,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = clog2_min1(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             s1_q, s2_q;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser keeps sampling regardless of the enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= x;
            s2_q <= s1_q;
        end
    end

    // Stability rules: agreement clears progress; the last qualifying tick
    // commits the new level and fires the matching edge pulse.
    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q == q_q) begin
            cnt_d = '0;
        end else if (tick && en) begin
            if (cnt_q == CNT_LAST) begin
                q_d    = s2_q;
                cnt_d  = '0;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Level, counter and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            q_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/antirebote_multicanal.sv
// N-channel debouncer: shared sample-rate prescaler feeding independent
// per-channel debounce slices.
module antirebote_multicanal
    import antirebote_pkg::*;
#(
    parameter int              N_CH         = 4,
    parameter int              STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int              PRESCALE     = DEF_PRESCALE,
    parameter logic [N_CH-1:0] INVERT       = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] q,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    localparam int               PRE_W    = clog2_min1(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic [N_CH-1:0]  x;

    // Prescaler advances only while enabled, wrapping at PRESCALE-1.
    always_comb begin
        pre_d = pre_q;
        if (en) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Gated by en so a frozen count at PRESCALE-1 cannot produce ticks.
    assign tick = en && (pre_q == PRE_LAST);
    assign x    = btn ^ INVERT;

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        antirebote_canal #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_canal (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .en   (en),
            .x    (x[i]),
            .q    (q[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule
